// File: rtl/rgb_pwm_sequencer_if.sv
// rgb_pwm_sequencer_if: enable in, PWM drives and sequence status out
interface rgb_pwm_sequencer_if;
   logic       en;
   logic       pwm_red;
   logic       pwm_green;
   logic       pwm_blue;
   logic [1:0] colour_idx;
   logic       busy;
   logic       cycle_done;
   modport master (output en, input pwm_red, pwm_green, pwm_blue, colour_idx, busy, cycle_done);
   modport slave (input en, output pwm_red, pwm_green, pwm_blue, colour_idx, busy, cycle_done);
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: red -> green -> blue fade-in/hold/fade-out PWM for the SB_RGBA_DRV inputs
module rgb_pwm_sequencer #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 46875,
   parameter int HOLD_STEPS  = 64
) (
   input logic                hw_clk,
   input logic                rst,
   rgb_pwm_sequencer_if.slave bus
);
   localparam int TW = $clog2(STEP_CYCLES);
   localparam int HW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
   localparam logic [PWM_BITS-1:0] MAX = '1;
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
   typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_e;
   state_e              state_q, state_d;
   logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
   logic [1:0]          colour_q, colour_d;
   logic [2:0]          pwm_q, pwm_d;
   logic                busy_q, done_q, done_d;
   logic                tick, run, lit;
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      hold_d   = hold_q;
      colour_d = colour_q;
      done_d   = 1'b0;
      tick     = state_q != IDLE && tick_cnt_q == TICK_LAST;
      case (state_q)
         IDLE: state_d = FADE_IN;
         FADE_IN: if (tick) begin
            state_d = duty_q == MAX ? HOLD : FADE_IN;
            hold_d  = '0;
            duty_d  = duty_q == MAX ? duty_q : duty_q + 1'b1;
         end
         HOLD: if (tick) begin
            state_d = hold_q == HOLD_LAST ? FADE_OUT : HOLD;
            hold_d  = hold_q == HOLD_LAST ? hold_q : hold_q + 1'b1;
         end
         default: if (tick) begin
            state_d  = duty_q == '0 ? FADE_IN : FADE_OUT;
            duty_d   = duty_q == '0 ? duty_q : duty_q - 1'b1;
            colour_d = duty_q != '0 ? colour_q : colour_q == 2'd2 ? 2'd0 : colour_q + 2'd1;
            done_d   = duty_q == '0 && colour_q == 2'd2;
         end
      endcase
      // Dropping en beats any tick arriving on the same edge
      if (!bus.en) begin
         state_d  = IDLE;
         duty_d   = '0;
         hold_d   = '0;
         colour_d = '0;
         done_d   = 1'b0;
      end
   end
   assign run           = bus.en && state_q != IDLE;
   assign tick_cnt_d    = run && !tick ? tick_cnt_q + 1'b1 : '0;
   assign pwm_cnt_d     = run ? pwm_cnt_q + 1'b1 : '0;
   assign duty_active_d = !bus.en ? '0 : pwm_cnt_q == MAX ? duty_q : duty_active_q;
   assign lit           = bus.en && pwm_cnt_q < duty_active_q;
   assign pwm_d         = {lit && colour_q == 2'd2, lit && colour_q == 2'd1, lit && colour_q == 2'd0};
   always_ff @(posedge hw_clk) begin
      if (rst) begin
         state_q       <= IDLE;
         tick_cnt_q    <= '0;
         pwm_cnt_q     <= '0;
         hold_q        <= '0;
         duty_q        <= '0;
         duty_active_q <= '0;
         colour_q      <= '0;
         pwm_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         hold_q        <= hold_d;
         duty_q        <= duty_d;
         duty_active_q <= duty_active_d;
         colour_q      <= colour_d;
         pwm_q         <= pwm_d;
         busy_q        <= state_d != IDLE;
         done_q        <= done_d;
      end
   end
   assign bus.pwm_red    = pwm_q[0];
   assign bus.pwm_green  = pwm_q[1];
   assign bus.pwm_blue   = pwm_q[2];
   assign bus.colour_idx = colour_q;
   assign bus.busy       = busy_q;
   assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: directed + random enable/reset stimulus against an arithmetic timeline model
module tb_rgb_pwm_sequencer;
   localparam int M = 15;
   localparam int H = 2;
   localparam int S = 4;
   localparam int P = 16;
   localparam int L = 2 * M + H + 2;
   logic clk = 1'b0;
   logic rst;
   int   n = -1;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt;
   rgb_pwm_sequencer_if bus ();
   rgb_pwm_sequencer #(.PWM_BITS(4), .STEP_CYCLES(S), .HOLD_STEPS(H)) dut (
      .hw_clk(clk),
      .rst   (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   // n = clocks since the sequence left IDLE, -1 while idle; everything derives from it
   function automatic int duty_at(int k);
      int j = k % L;
      return j <= M ? j : j <= M + H ? M : 2 * M + H + 1 - j;
   endfunction
   function automatic int colour_at(int t);
      return (t / S / L) % 3;
   endfunction
   function automatic int dact(int t);
      return t < P ? 0 : duty_at((P * (t / P) - 1) / S);
   endfunction
   function automatic int exp_pwm(int c);
      return n < 1 ? 0 : int'(colour_at(n - 1) == c && (n - 1) % P < dact(n - 1));
   endfunction
   function automatic int exp_done();
      return int'(n > 0 && n % S == 0 && (n / S) % (3 * L) == 0);
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d n=%0d t=%0t", tag, got, exp, n, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      n = (rst || !bus.en) ? -1 : n + 1;
      @(negedge clk);
      chk("pwm_red", bus.pwm_red, exp_pwm(0));
      chk("pwm_green", bus.pwm_green, exp_pwm(1));
      chk("pwm_blue", bus.pwm_blue, exp_pwm(2));
      chk("colour_idx", bus.colour_idx, n < 0 ? 0 : colour_at(n));
      chk("busy", bus.busy, n >= 0);
      chk("cycle_done", bus.cycle_done, exp_done());
      if (bus.cycle_done) done_cnt++;
   endtask
   initial begin
      rst = 1'b1;
      bus.en = 1'b1;
      done_cnt = 0;
      repeat (3) step();
      rst = 1'b0;
      bus.en = 1'b0;
      repeat (100) step();
      bus.en = 1'b1;
      done_cnt = 0;
      repeat (3 * L * S + 4) step();
      chk("wrap_done_count", done_cnt, 1);
      chk("wrap_colour", bus.colour_idx, 0);
      for (int i = 0; i < 2000 && !(colour_at(n) == 1 && duty_at(n / S) == 7 && (n / S) % L > M + H); i++) step();
      chk("abort_reached", colour_at(n) == 1 && duty_at(n / S) == 7 && (n / S) % L > M + H, 1);
      bus.en = 1'b0;
      step();
      chk("abort_busy", bus.busy, 0);
      bus.en = 1'b1;
      repeat (200) step();
      for (int i = 0; i < 2000 && !(n % S == S - 1 && (n / S) % L > M && (n / S) % L <= M + H); i++) step();
      chk("hold_tick_reached", n % S == S - 1 && (n / S) % L > M && (n / S) % L <= M + H, 1);
      bus.en = 1'b0;
      step();
      chk("hold_abort_busy", bus.busy, 0);
      bus.en = 1'b1;
      repeat (150) step();
      rst = 1'b1;
      step();
      chk("rst_en_busy", bus.busy, 0);
      rst = 1'b0;
      repeat (50) step();
      repeat (3000) begin
         rst = $urandom_range(0, 399) == 0;
         bus.en = $urandom_range(0, 199) != 0;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
